// File: rtl/fu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fu_pkg                                                                     |
// | Function-select codes and sequencer state encoding for seq_function_unit.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fu_pkg;

    localparam logic [3:0] c_FS_MOVA  = 4'b0000;
    localparam logic [3:0] c_FS_NOTA  = 4'b0001;
    localparam logic [3:0] c_FS_NOTB  = 4'b0010;
    localparam logic [3:0] c_FS_AND   = 4'b0011;
    localparam logic [3:0] c_FS_NAND  = 4'b0100;
    localparam logic [3:0] c_FS_OR    = 4'b0101;
    localparam logic [3:0] c_FS_SHL3  = 4'b0110;
    localparam logic [3:0] c_FS_MASK4 = 4'b0111;
    localparam logic [3:0] c_FS_ADD   = 4'b1000;
    localparam logic [3:0] c_FS_SUB   = 4'b1001;
    localparam logic [3:0] c_FS_INCB  = 4'b1010;
    localparam logic [3:0] c_FS_ADD2  = 4'b1011;
    localparam logic [3:0] c_FS_NEGB  = 4'b1100;
    localparam logic [3:0] c_FS_MUL   = 4'b1101;
    localparam logic [3:0] c_FS_DIV   = 4'b1110;
    localparam logic [3:0] c_FS_MOD   = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } fu_state_t;

endpackage
`default_nettype wire

// File: rtl/fu_comb_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fu_comb_alu                                                                |
// | Combinational result and C/V flags for every single-cycle function code.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fu_comb_alu
    import fu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       fs,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH:0]   w_sum;
    logic             w_c_msb;

    // All arithmetic codes are folded onto one adder: x + y + cin.
    always_comb begin
        w_x   = '0;
        w_y   = '0;
        w_cin = 1'b0;
        case (fs)
            c_FS_ADD:  begin w_x = a; w_y = b;                  end
            c_FS_SUB:  begin w_x = a; w_y = ~b;  w_cin = 1'b1;  end
            c_FS_INCB: begin w_x = b;            w_cin = 1'b1;  end
            c_FS_ADD2: begin w_x = a; w_y = WIDTH'(2);          end
            c_FS_NEGB: begin          w_y = ~b;  w_cin = 1'b1;  end
            default:   ;
        endcase
    end

    assign w_sum   = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
    // Carry into the MSB recovered from the MSB sum bit and its addends.
    assign w_c_msb = w_x[WIDTH-1] ^ w_y[WIDTH-1] ^ w_sum[WIDTH-1];

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (fs)
            c_FS_MOVA:  y = a;
            c_FS_NOTA:  y = ~a;
            c_FS_NOTB:  y = ~b;
            c_FS_AND:   y = a & b;
            c_FS_NAND:  y = ~(a & b);
            c_FS_OR:    y = a | b;
            c_FS_SHL3:  y = {b[WIDTH-4:0], 3'b000};
            c_FS_MASK4: y = {{(WIDTH-4){1'b0}}, b[3:0]};
            c_FS_ADD, c_FS_SUB, c_FS_INCB, c_FS_ADD2, c_FS_NEGB: begin
                y = w_sum[WIDTH-1:0];
                c = w_sum[WIDTH];
                v = w_sum[WIDTH] ^ w_c_msb;
            end
            default:    y = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seq_function_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | seq_function_unit                                                          |
// | Function unit with single-cycle ALU ops and iterative MUL/DIV/MOD.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module seq_function_unit
    import fu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       FS,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    output logic [WIDTH-1:0] result,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam int            CW         = $clog2(WIDTH);
    localparam logic [CW-1:0] c_CNT_LAST = CW'(WIDTH - 1);

    fu_state_t        r_state;
    fu_state_t        w_state_nx;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_mod;
    logic [WIDTH-1:0] r_result;
    logic             r_v, r_c, r_n, r_z, r_done;

    logic [WIDTH-1:0] w_alu_y;
    logic             w_alu_c, w_alu_v;
    logic             w_load, w_fin;
    logic [WIDTH-1:0] w_res_nx;
    logic             w_c_nx, w_v_nx;

    fu_comb_alu #(.WIDTH(WIDTH)) u_alu (
        .fs (FS),
        .a  (OpA),
        .b  (OpB),
        .y  (w_alu_y),
        .c  (w_alu_c),
        .v  (w_alu_v)
    );

    // Multiply step: {hi,lo} holds partial product over the remaining multiplier bits.
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_hi, w_mul_lo;
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_hi  = w_mul_sum[WIDTH:1];
    assign w_mul_lo  = {w_mul_sum[0], r_lo[WIDTH-1:1]};

    // Divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_rem, w_div_q;
    assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_b});
    assign w_div_rem   = w_div_ok ? WIDTH'(w_div_shift - {1'b0, r_b}) : w_div_shift[WIDTH-1:0];
    assign w_div_q     = {r_lo[WIDTH-2:0], w_div_ok};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_fin      = 1'b0;
        w_res_nx   = r_result;
        w_c_nx     = 1'b0;
        w_v_nx     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (FS == c_FS_MUL) begin
                        w_state_nx = ST_MUL;
                        w_load     = 1'b1;
                    end else if (FS == c_FS_DIV || FS == c_FS_MOD) begin
                        w_state_nx = ST_DIV;
                        w_load     = 1'b1;
                    end else begin
                        w_fin    = 1'b1;
                        w_res_nx = w_alu_y;
                        w_c_nx   = w_alu_c;
                        w_v_nx   = w_alu_v;
                    end
                end
            end
            ST_MUL: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_fin      = 1'b1;
                    w_res_nx   = w_mul_lo;
                    w_c_nx     = (w_mul_hi != '0);
                end
            end
            ST_DIV: begin
                // A zero divisor naturally yields all-ones quotient and remainder = OpA.
                if (r_cnt == c_CNT_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_fin      = 1'b1;
                    w_res_nx   = r_mod ? w_div_rem : w_div_q;
                    w_v_nx     = (r_b == '0);
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_mod    <= 1'b0;
            r_result <= '0;
            r_v      <= 1'b0;
            r_c      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_fin) begin
                r_result <= w_res_nx;
                r_v      <= w_v_nx;
                r_c      <= w_c_nx;
                r_n      <= w_res_nx[WIDTH-1];
                r_z      <= (w_res_nx == '0);
            end
            if (w_load) begin
                r_a   <= OpA;
                r_b   <= OpB;
                r_hi  <= '0;
                r_lo  <= (FS == c_FS_MUL) ? OpB : OpA;
                r_mod <= (FS == c_FS_MOD);
                r_cnt <= '0;
            end else if (r_state == ST_MUL || r_state == ST_DIV) begin
                r_hi  <= (r_state == ST_MUL) ? w_mul_hi : w_div_rem;
                r_lo  <= (r_state == ST_MUL) ? w_mul_lo : w_div_q;
                r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
            end
        end
    end

    assign result = r_result;
    assign V      = r_v;
    assign C      = r_c;
    assign N      = r_n;
    assign Z      = r_z;
    assign busy   = (r_state != ST_IDLE);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: doc/seq_function_unit.md
SEQ_FUNCTION_UNIT -- requirements
Module: seq_function_unit

Interface
REQ-001 Parameter WIDTH, default 16: operand/result width; legal range 8..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 FS  input  4  function select, captured with start.
REQ-006 OpA  input  WIDTH  operand A, captured with start.
REQ-007 OpB  input  WIDTH  operand B, captured with start.
REQ-008 result  output  WIDTH  registered result of last completed operation.
REQ-009 V  output  1  registered overflow flag.
REQ-010 C  output  1  registered carry/unsigned-overflow flag.
REQ-011 N  output  1  registered copy of result[WIDTH-1].
REQ-012 Z  output  1  registered; 1 iff result is all zeros.
REQ-013 busy  output  1  high while a multi-cycle operation is in progress.
REQ-014 done  output  1  one-cycle pulse in the cycle result/flags update.

Function
REQ-015 FS codes: 0000 movA, 0001 notA, 0010 notB, 0011 and, 0100 nand, 0101 or, 0110 OpB<<3, 0111 {0,OpB[3:0]}, 1000 A+B, 1001 A-B, 1010 B+1, 1011 A+2, 1100 -B, 1101 MUL, 1110 DIV, 1111 MOD.
REQ-016 Codes 0000-1100 single-cycle: start at edge k -> result, flags, done=1 valid after edge k; busy stays 0.
REQ-017 Codes 1101-1111 multi-cycle: start at edge k -> busy=1 after edge k; result, flags, done=1 after edge k+WIDTH, busy=0 in the same cycle.
REQ-018 FSM states IDLE, MUL, DIV; IDLE->MUL on start with 1101; IDLE->DIV on start with 1110/1111; MUL/DIV->IDLE when iteration counter reaches WIDTH-1.
REQ-019 MUL: unsigned shift-add, one bit of OpB per cycle; result = low WIDTH bits of product; C=1 iff high WIDTH bits nonzero; V=0.
REQ-020 DIV/MOD: unsigned restoring division, one quotient bit per cycle; DIV returns quotient, MOD returns remainder; C=0, V=0.
REQ-021 Divide by zero: DIV result all ones, MOD result = OpA, V=1, C=0; still takes WIDTH cycles.
REQ-022 Add/sub/inc/neg: C = carry out of bit WIDTH-1 (subtract as A+~B+1); V = carry into MSB XOR carry out of MSB.
REQ-023 Logic/shift/mask codes: C=0, V=0; 0110 discards bits shifted past MSB.
REQ-024 start while busy=1 ignored, no effect on operands, state or outputs.
REQ-025 result and all flags hold their value between completions; done=0 otherwise.
REQ-026 Operand inputs may change after the start cycle without affecting the operation in progress.
REQ-027 Back-to-back: start asserted in the done cycle of a multi-cycle op is accepted.

Reset
REQ-028 reset=1 at an edge: state IDLE, counter 0, result 0, V=C=N=0, Z=1, busy=0, done=0.
REQ-029 Reset mid-operation aborts it; no done pulse for the aborted operation; reset overrides start in the same cycle.

Structure
REQ-030 Shared package fu_pkg holds FS code constants and the FSM state enumeration.
REQ-031 One sub-module fu_comb_alu (combinational, parametrised WIDTH) computes all single-cycle results, C and V; the sequencer owns FSM, counter, MUL/DIV datapath and output registers.

Verification
REQ-032 WIDTH=16, FS=1000, A=0x7FFF, B=0x0001 -> next cycle result=0x8000, V=1, C=0, N=1, Z=0, done=1.
REQ-033 FS=1001, A=0x0005, B=0x0005 -> result=0x0000, Z=1, C=1, V=0, one-cycle latency.
REQ-034 FS=1101, A=0x0100, B=0x0101 -> busy 16 cycles, then result=0x0100, C=1, done one cycle; start pulses during busy ignored.
REQ-035 FS=1110 A=100 B=7 -> result=14; FS=1111 same operands -> result=2; FS=1110 B=0 -> 0xFFFF, V=1.
REQ-036 Start FS=1101, assert reset at cycle 5 -> busy=0, result=0, Z=1, no done; new start next cycle completes normally.
REQ-037 Repeat REQ-032 and REQ-034 at WIDTH=8 and WIDTH=32 with scaled operands; latency = WIDTH cycles.
